// File: rtl/loader_pkg.sv
// Shared types and constants for the front-panel memory loader.
package loader_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR_WAIT = 3'd1,
        S_DATA_WAIT = 3'd2,
        S_WRITE     = 3'd3,
        S_INCR      = 3'd4
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          armed_q, armed_d;
    logic          pulse_q, pulse_d;

    // Synchronizer resets to "pressed" so a button held through reset is never armed
    // until it has been seen released.
    always_comb begin
        sync_d  = {sync_q[0], btn_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        armed_d = armed_q | (~sync_q[1] & ~level_q);
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync_q[1];
            pulse_d = sync_q[1] & armed_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/panel_loader.sv
// Front-panel loader: switches and two buttons enter an address, then a stream of
// data words written to consecutive RAM locations while the CPU is held in reset.
//
// state     | meaning
// IDLE      | CPU running, panel inactive
// ADDR_WAIT | waiting for start address on sw
// DATA_WAIT | waiting for a data word on sw
// WRITE     | one-cycle RAM write strobe
// INCR      | advance write address
module panel_loader
    import loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    input  logic       btn_enter,
    input  logic       btn_load,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mem_wren,
    output logic       LD_ADDR,
    output logic       LD_DAT,
    output logic       cpu_hold,
    output logic [7:0] wr_count,
    output logic [2:0] STATE
);

    logic       enter_p;
    logic       load_p;
    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] cnt_q, cnt_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (btn_enter),
        .pulse_o (enter_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (btn_load),
        .pulse_o (load_p)
    );

    // Load is checked first so a simultaneous enter never latches or writes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load_p) begin
                    state_d = S_ADDR_WAIT;
                    cnt_d   = 8'h00;
                end
            end
            S_ADDR_WAIT: begin
                if (load_p) begin
                    state_d = S_IDLE;
                end else if (enter_p) begin
                    addr_d  = sw;
                    state_d = S_DATA_WAIT;
                end
            end
            S_DATA_WAIT: begin
                if (load_p) begin
                    state_d = S_IDLE;
                end else if (enter_p) begin
                    data_d  = sw;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d   = sat_inc8(cnt_q);
                state_d = S_INCR;
            end
            S_INCR: begin
                addr_d  = addr_q + 8'd1;
                state_d = S_DATA_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Control outputs decode straight from the state register, so reset clears them at once.
    assign mem_wren = (state_q == S_WRITE);
    assign LD_ADDR  = (state_q == S_ADDR_WAIT);
    assign LD_DAT   = (state_q == S_DATA_WAIT);
    assign cpu_hold = (state_q != S_IDLE);
    assign STATE    = state_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_panel_loader.sv
// Randomized bench for panel_loader against a session-level reference model.
module tb_panel_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic       btn_enter;
    logic       btn_load;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_wren;
    logic       LD_ADDR;
    logic       LD_DAT;
    logic       cpu_hold;
    logic [7:0] wr_count;
    logic [2:0] STATE;

    always #5 clk = ~clk;

    panel_loader #(.DEBOUNCE_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_load  (btn_load),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wren  (mem_wren),
        .LD_ADDR   (LD_ADDR),
        .LD_DAT    (LD_DAT),
        .cpu_hold  (cpu_hold),
        .wr_count  (wr_count),
        .STATE     (STATE)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_wr  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: panel mode (0 idle, 1 address entry, 2 data entry) and session values.
    int          m_st;
    logic [7:0]  m_addr, m_data, m_cnt;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;

    task automatic model_reset();
        m_st = 0; m_addr = 8'h00; m_data = 8'h00; m_cnt = 8'h00;
        exp_q.delete();
    endtask

    task automatic model_press(input bit ent, input bit ld, input logic [7:0] v);
        if (ld) begin
            if (m_st == 0) begin
                m_st = 1;
                m_cnt = 8'h00;
            end else begin
                m_st = 0;
            end
        end else if (ent) begin
            if (m_st == 1) begin
                m_addr = v;
                m_st = 2;
            end else if (m_st == 2) begin
                m_data = v;
                exp_q.push_back({m_addr, v});
                m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
                m_addr = m_addr + 8'd1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mem_wren) begin
            n_wr++;
            chk("wr_state", STATE, 3);
            chk("wr_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", mem_addr, mon_e[15:8]);
                chk("wr_data", mem_data, mon_e[7:0]);
            end
        end
    end

    task automatic check_state(input string tag);
        chk({tag, "_state"}, STATE, m_st);
        chk({tag, "_addr"}, mem_addr, m_addr);
        chk({tag, "_data"}, mem_data, m_data);
        chk({tag, "_count"}, wr_count, m_cnt);
        chk({tag, "_hold"}, cpu_hold, m_st != 0);
        chk({tag, "_ld_addr"}, LD_ADDR, m_st == 1);
        chk({tag, "_ld_dat"}, LD_DAT, m_st == 2);
        chk({tag, "_pending_wr"}, exp_q.size(), 0);
    endtask

    task automatic press(input bit ent, input bit ld, input logic [7:0] v, input string tag);
        sw = v;
        model_press(ent, ld, v);
        @(negedge clk);
        btn_enter = ent;
        btn_load  = ld;
        repeat (25) @(negedge clk);
        btn_enter = 1'b0;
        btn_load  = 1'b0;
        repeat (25) @(negedge clk);
        check_state(tag);
    endtask

    task automatic ensure_data_wait();
        if (m_st == 0) press(1'b0, 1'b1, 8'h00, "to_addr");
        if (m_st == 1) press(1'b1, 1'b0, 8'($urandom), "to_data");
    endtask

    int wr_before;
    logic [7:0] v;

    initial begin
        reset = 1'b0; btn_enter = 1'b0; btn_load = 1'b0; sw = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_wren", mem_wren, 0);
        check_state("rst");
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Basic session: address 10, data A5
        press(1'b0, 1'b1, 8'h00, "load");
        press(1'b1, 1'b0, 8'h10, "addr10");
        press(1'b1, 1'b0, 8'hA5, "dataA5");

        // Simultaneous load and enter in DATA_WAIT: load wins
        press(1'b1, 1'b1, 8'h3C, "both");

        // Address wrap at FF
        press(1'b0, 1'b1, 8'h00, "load2");
        press(1'b1, 1'b0, 8'hFF, "addrFF");
        press(1'b1, 1'b0, 8'h01, "wrapFF");

        // Bouncing enter, then a clean hold: exactly one write
        v = 8'($urandom);
        sw = v;
        model_press(1'b1, 1'b0, v);
        wr_before = n_wr;
        for (int i = 0; i < 40; i++) begin
            btn_enter = ((i / 3) % 2) == 0;
            @(negedge clk);
        end
        btn_enter = 1'b1;
        repeat (25) @(negedge clk);
        btn_enter = 1'b0;
        repeat (25) @(negedge clk);
        chk("bounce_writes", n_wr - wr_before, 1);
        check_state("bounce");

        // Random session traffic
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2)      press(1'b0, 1'b1, 8'($urandom), "rnd_load");
            else if (r < 3) press(1'b1, 1'b1, 8'($urandom), "rnd_both");
            else            press(1'b1, 1'b0, 8'($urandom), "rnd_enter");
        end

        // Reset in the WRITE cycle, with both buttons held across reset release
        ensure_data_wait();
        sw = 8'h5A;
        @(negedge clk);
        btn_enter = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (STATE == 3'd3) break;
        end
        chk("reach_write", STATE, 3);
        reset = 1'b0;
        #1;
        chk("async_wren", mem_wren, 0);
        model_reset();
        check_state("rst_write");
        btn_load = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check_state("held_after_rst");
        btn_load = 1'b0;
        btn_enter = 1'b0;
        repeat (25) @(negedge clk);
        check_state("released");
        press(1'b0, 1'b1, 8'h00, "load_after_rst");

        // Long session: count saturates, address wraps
        press(1'b1, 1'b0, 8'($urandom), "long_addr");
        for (int i = 0; i < 300; i++)
            press(1'b1, 1'b0, 8'($urandom), "long_wr");
        chk("sat_count", wr_count, 8'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/panel_loader.md
PANEL_LOADER -- requirements
Module: panel_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 16, number of consecutive stable samples a button must hold before its debounced level changes.
REQ-002 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 sw  input  8  raw front-panel switch value (address or data).
REQ-005 btn_enter  input  1  raw, asynchronous, active-high pushbutton; commits the sw value.
REQ-006 btn_load  input  1  raw, asynchronous, active-high pushbutton; enters and exits load mode.
REQ-007 mem_addr  output  8  RAM write address.
REQ-008 mem_data  output  8  RAM write data.
REQ-009 mem_wren  output  1  RAM write strobe, one cycle wide.
REQ-010 LD_ADDR  output  1  high while waiting for an address entry.
REQ-011 LD_DAT  output  1  high while waiting for a data entry.
REQ-012 cpu_hold  output  1  holds the downstream CPU in reset while high.
REQ-013 wr_count  output  8  number of words written in the current load session.
REQ-014 STATE  output  3  encoded FSM state, for display.

Function
REQ-015 Each button SHALL pass through a 2-FF synchronizer and then a debouncer; a debounced level SHALL change only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-016 Each debounced button SHALL produce a one-cycle pulse on its 0->1 transition only; holding a button SHALL NOT repeat the pulse.
REQ-017 FSM states (STATE value): IDLE=0, ADDR_WAIT=1, DATA_WAIT=2, WRITE=3, INCR=4.
REQ-018 IDLE: cpu_hold=0, LD_ADDR=0, LD_DAT=0; a load pulse SHALL go to ADDR_WAIT and clear wr_count to 0.
REQ-019 ADDR_WAIT: cpu_hold=1, LD_ADDR=1; an enter pulse SHALL latch sw into mem_addr and go to DATA_WAIT; a load pulse SHALL go to IDLE.
REQ-020 DATA_WAIT: cpu_hold=1, LD_DAT=1; an enter pulse SHALL latch sw into mem_data and go to WRITE; a load pulse SHALL go to IDLE.
REQ-021 WRITE: mem_wren=1 for exactly one cycle, with mem_addr and mem_data stable; wr_count SHALL increment and saturate at 8'hFF; next state is always INCR.
REQ-022 INCR: mem_addr SHALL increment by 1 modulo 256 (8'hFF -> 8'h00); next state is always DATA_WAIT.
REQ-023 In WRITE and INCR, cpu_hold SHALL be 1, LD_ADDR and LD_DAT SHALL be 0, and button pulses SHALL be ignored.
REQ-024 If load and enter pulse in the same cycle in ADDR_WAIT or DATA_WAIT, load SHALL take priority: go to IDLE with no latch and no write.
REQ-025 mem_wren SHALL never be asserted outside WRITE.
REQ-026 cpu_hold SHALL deassert on the first cycle of IDLE; mem_addr and mem_data SHALL keep their last values there.
REQ-027 All outputs SHALL be registered, or decoded only from the state register.

Reset
REQ-028 reset low SHALL immediately force: state=IDLE, mem_addr=0, mem_data=0, mem_wren=0, LD_ADDR=0, LD_DAT=0, cpu_hold=0, wr_count=0, debouncer counters=0, and debounced levels=0.
REQ-029 A reset during WRITE SHALL abort the write, with mem_wren low asynchronously; no partial session state SHALL survive.
REQ-030 After reset deasserts, a button already held SHALL NOT generate a pulse until it is released and pressed again.

Structure
REQ-031 Package loader_pkg SHALL hold the state enum typedef (3-bit) and the DEBOUNCE_CYCLES default constant.
REQ-032 Sub-module btn_debounce (synchronizer, stability counter, edge pulse) SHALL be instantiated twice; the FSM and datapath SHALL live in panel_loader.

Verification
REQ-033 Reset, then load, then sw=8'h10 with enter, then sw=8'hA5 with enter -> one mem_wren pulse at addr 8'h10 with data 8'hA5; then mem_addr=8'h11, STATE=2, wr_count=1.
REQ-034 Session with start address 8'hFF and data 8'h01 -> write at 8'hFF, then mem_addr wraps to 8'h00.
REQ-035 Bounce btn_enter 0/1 every 3 cycles for 40 cycles with DEBOUNCE_CYCLES=16, then hold high -> exactly one enter pulse and one write.
REQ-036 In DATA_WAIT, load and enter pulses in the same cycle -> STATE=0, cpu_hold=0, no mem_wren, mem_data unchanged.
REQ-037 Assert reset in the WRITE cycle -> mem_wren drops without waiting for clk; all outputs reach their reset values; STATE=0.
REQ-038 Perform 300 writes in one session -> wr_count saturates at 8'hFF and mem_addr wraps correctly.
